// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the decode_queue ID stage: RV32 base opcode
// constants, the register-index width helper and the decoded instruction
// record that travels from the FIFO head into the output slot.
// No ports (package).
// -----------------------------------------------------------------------------
package decoder_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Register index width for a register file of nregs entries.
  function automatic int reg_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  // Instruction fields encode 5-bit register indices.
  localparam int REG_W = reg_w(32);

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [31:0]      imm;
    logic             illegal;
  } decoded_instr_t;

endpackage

// File: rtl/instr_field_decode.sv
// -----------------------------------------------------------------------------
// instr_field_decode
// Purely combinational field decoder. Extracts register pointers and the
// sign-extended immediate for the supported opcode set; unused pointers are
// zero and unsupported opcodes produce illegal=1 with all fields zero.
// Ports:
//   instr_i  in  32  instruction word
//   pc_i     in  32  instruction PC
//   dec_o    out     decoded_instr_t record
// -----------------------------------------------------------------------------
module instr_field_decode
  import decoder_pkg::*;
(
  input  logic [31:0]    instr_i,
  input  logic [31:0]    pc_i,
  output decoded_instr_t dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.instr = instr_i;
    dec_o.pc    = pc_i;
    case (instr_i[6:0])
      LUI, AUIPC: begin
        dec_o.rd  = instr_i[11:7];
        dec_o.imm = {instr_i[31:12], 12'b0};
      end
      OP_IMM, LOAD, JALR: begin
        dec_o.rs1 = instr_i[19:15];
        dec_o.rd  = instr_i[11:7];
        dec_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP: begin
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        dec_o.rd  = instr_i[11:7];
      end
      STORE: begin
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        dec_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      BRANCH: begin
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        dec_o.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
      end
      JAL: begin
        dec_o.rd  = instr_i[11:7];
        dec_o.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
// Buffered ID stage: DEPTH-entry instruction FIFO, head decode, and a
// registered output slot with valid/ready handshakes on both sides.
// Optional feature macro: DECODE_QUEUE_SCOREBOARD_EN adds an NREGS-bit busy
// vector that holds back heads with RAW hazards against in-flight writes.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush_i                     drop FIFO and output slot contents
//   in_valid_i/in_ready_o       fetch handshake
//   in_instr_i, in_pc_i         fetched instruction and PC
//   out_valid_o/out_ready_i     execute handshake
//   out_instr_o, out_pc_o       output slot instruction and PC
//   out_rs1_o/out_rs2_o/out_rd_o register pointers (0 when unused)
//   out_imm_o, out_illegal_o    immediate, unsupported-opcode flag
//   wb_valid_i, wb_rd_i         writeback retiring a destination register
// -----------------------------------------------------------------------------
module decode_queue
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_instr_i,
  input  logic [31:0]              in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_instr_o,
  output logic [31:0]              out_pc_o,
  output logic [reg_w(NREGS)-1:0]  out_rs1_o,
  output logic [reg_w(NREGS)-1:0]  out_rs2_o,
  output logic [reg_w(NREGS)-1:0]  out_rd_o,
  output logic [31:0]              out_imm_o,
  output logic                     out_illegal_o,
  input  logic                     wb_valid_i,
  input  logic [reg_w(NREGS)-1:0]  wb_rd_i
);

  localparam int RW = reg_w(NREGS);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]    instr_mem_q [DEPTH];
  logic [31:0]    pc_mem_q    [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           out_valid_q, out_valid_d;
  decoded_instr_t slot_q, slot_d;
  decoded_instr_t head_dec;

  logic fifo_empty, fifo_full;
  logic push, load, issue, hazard;
  logic [RW-1:0] head_rs1, head_rs2;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Registered full flag: a pop this cycle reopens in_ready_o only next cycle.
  assign in_ready_o = !fifo_full;
  assign issue      = out_valid_q && out_ready_i;
  assign push       = in_valid_i && !fifo_full && !flush_i;
  assign load       = !fifo_empty && (!out_valid_q || out_ready_i) && !hazard && !flush_i;

  instr_field_decode u_head_decode (
    .instr_i (instr_mem_q[rd_ptr_q[AW-1:0]]),
    .pc_i    (pc_mem_q[rd_ptr_q[AW-1:0]]),
    .dec_o   (head_dec)
  );

  assign head_rs1 = RW'(head_dec.rs1);
  assign head_rs2 = RW'(head_dec.rs2);

`ifdef DECODE_QUEUE_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;
  logic             rs1_hit, rs2_hit;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
    // Applied after the clear so a same-register set wins.
    if (issue && (out_rd_o != '0)) busy_d[out_rd_o] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // The slot's rd is not yet in busy_q, so it is compared directly.
  assign rs1_hit = (head_rs1 != '0) &&
                   (busy_q[head_rs1] || (out_valid_q && (out_rd_o == head_rs1)));
  assign rs2_hit = (head_rs2 != '0) &&
                   (busy_q[head_rs2] || (out_valid_q && (out_rd_o == head_rs2)));
  assign hazard  = rs1_hit || rs2_hit;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid_i, wb_rd_i, head_rs1, head_rs2};
  assign hazard    = 1'b0;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (load) begin
        rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
        slot_d      = head_dec;
        out_valid_d = 1'b1;
      end else if (issue) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      slot_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
    end
  end

  // Storage is data-only; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q[AW-1:0]] <= in_instr_i;
      pc_mem_q[wr_ptr_q[AW-1:0]]    <= in_pc_i;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_instr_o   = slot_q.instr;
  assign out_pc_o      = slot_q.pc;
  assign out_rs1_o     = RW'(slot_q.rs1);
  assign out_rs2_o     = RW'(slot_q.rs2);
  assign out_rd_o      = RW'(slot_q.rd);
  assign out_imm_o     = slot_q.imm;
  assign out_illegal_o = slot_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [31:0] in_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic [4:0]  out_rs1_o;
  logic [4:0]  out_rs2_o;
  logic [4:0]  out_rd_o;
  logic [31:0] out_imm_o;
  logic        out_illegal_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;

  decode_queue #(.DEPTH(4), .NREGS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .in_pc_i       (in_pc_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_pc_o      (out_pc_o),
    .out_rs1_o     (out_rs1_o),
    .out_rs2_o     (out_rs2_o),
    .out_rd_o      (out_rd_o),
    .out_imm_o     (out_imm_o),
    .out_illegal_o (out_illegal_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Scoreboard monitor: every issue pops the oldest expected instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_issue: got instr 0x%08h, required no issue", out_instr_o);
      end else begin
        e = exp_q.pop_front();
        chk("issue_instr",   out_instr_o,          e.instr);
        chk("issue_pc",      out_pc_o,             e.pc);
        chk("issue_rs1",     {27'b0, out_rs1_o},   {27'b0, e.rs1});
        chk("issue_rs2",     {27'b0, out_rs2_o},   {27'b0, e.rs2});
        chk("issue_rd",      {27'b0, out_rd_o},    {27'b0, e.rd});
        chk("issue_imm",     out_imm_o,            e.imm);
        chk("issue_illegal", {31'b0, out_illegal_o}, {31'b0, e.ill});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic enq(input logic [31:0] ins, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d, input logic [31:0] im, input logic il);
    exp_t e;
    logic ok;
    int   n;
    in_valid_i = 1'b1;
    in_instr_i = ins;
    in_pc_i    = pc_next;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 30) begin
      @(negedge clk);
      ok = in_ready_o;
      if (ok) begin
        e.instr = ins; e.pc = pc_next; e.rs1 = r1; e.rs2 = r2;
        e.rd = d; e.imm = im; e.ill = il;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      total++;
      $display("FAIL enq_timeout: got in_ready_o=0 for 30 cycles, required 1");
    end
    pc_next    = pc_next + 32'd4;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_instr_i = '0; in_pc_i = '0;
    out_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
    chk("rst_instr", out_instr_o, 32'd0);
    chk("rst_imm",   out_imm_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADDI x5,x1,-3: visible on the second cycle after enqueue.
    out_ready_i = 1'b1;
    enq(32'hFFD08293, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFD, 1'b0);
    @(negedge clk);
    chk("lat_e0_valid", {31'b0, out_valid_o}, 32'd0);
    @(negedge clk);
    chk("lat_e1_valid", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Back-to-back stream across all formats, including an illegal opcode.
    enq(32'hFE208EE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0); // BEQ x1,x2,-4
    enq(32'h001000EF, 5'd0, 5'd0, 5'd1, 32'h00000800, 1'b0); // JAL x1,+2048
    enq(32'h123451B7, 5'd0, 5'd0, 5'd3, 32'h12345000, 1'b0); // LUI x3
    enq(32'h0020A423, 5'd1, 5'd2, 5'd0, 32'h00000008, 1'b0); // SW x2,8(x1)
    enq(32'hFFFFF217, 5'd0, 5'd0, 5'd4, 32'hFFFFF000, 1'b0); // AUIPC x4
    enq(32'hFF0280E7, 5'd5, 5'd0, 5'd1, 32'hFFFFFFF0, 1'b0); // JALR x1,-16(x5)
    enq(32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1); // opcode 0x7F
    enq(32'h00412383, 5'd2, 5'd0, 5'd7, 32'h00000004, 1'b0); // LW x7,4(x2)
    wait_drain();

    // Backpressure: 1 in the slot plus 4 queued closes in_ready_o.
    out_ready_i = 1'b0;
    enq(32'h00100093, 5'd0, 5'd0, 5'd1, 32'h00000001, 1'b0); // ADDI x1,x0,1
    enq(32'h00200113, 5'd0, 5'd0, 5'd2, 32'h00000002, 1'b0);
    enq(32'h00300193, 5'd0, 5'd0, 5'd3, 32'h00000003, 1'b0);
    enq(32'h00400213, 5'd0, 5'd0, 5'd4, 32'h00000004, 1'b0);
    enq(32'h00500293, 5'd0, 5'd0, 5'd5, 32'h00000005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", {31'b0, in_ready_o}, 32'd0);
      chk("hold_instr", out_instr_o, 32'h00100093);
      chk("hold_imm",   out_imm_o, 32'h00000001);
      @(posedge clk); #1;
    end
    // Release while offering a sixth; it is accepted only after the reopen.
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_instr_i  = 32'h00600313;
    in_pc_i     = pc_next;
    @(negedge clk);
    chk("pop_no_reopen", {31'b0, in_ready_o}, 32'd0);
    chk("drain_valid",   {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reopen_ready", {31'b0, in_ready_o}, 32'd1);
    chk("drain_valid",  {31'b0, out_valid_o}, 32'd1);
    begin
      exp_t e;
      e.instr = 32'h00600313; e.pc = pc_next; e.rs1 = 5'd0; e.rs2 = 5'd0;
      e.rd = 5'd6; e.imm = 32'h00000006; e.ill = 1'b0;
      exp_q.push_back(e);
    end
    pc_next = pc_next + 32'd4;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", {31'b0, out_valid_o}, 32'd1);
      @(posedge clk); #1;
    end
    wait_drain();

    // Register scoreboard.
`ifdef DECODE_QUEUE_SCOREBOARD_EN
    enq(32'h00412383, 5'd2, 5'd0, 5'd7, 32'h00000004, 1'b0); // LW x7
    enq(32'h00138433, 5'd7, 5'd1, 5'd8, 32'h00000000, 1'b0); // ADD x8,x7,x1
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sb_stall", {31'b0, out_valid_o}, 32'd0);
    end
    @(posedge clk); #1;
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd7;
    @(posedge clk); #1;
    wb_valid_i = 1'b0;
    wb_rd_i    = 5'd0;
    @(negedge clk);
    chk("sb_no_bypass", {31'b0, out_valid_o}, 32'd0);
    @(negedge clk);
    chk("sb_release", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    enq(32'h000004B3, 5'd0, 5'd0, 5'd9, 32'h00000000, 1'b0); // ADD x9,x0,x0
    @(negedge clk);
    chk("sb_x0_e0", {31'b0, out_valid_o}, 32'd0);
    @(negedge clk);
    chk("sb_x0_e1", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    wait_drain();
`else
    enq(32'h00412383, 5'd2, 5'd0, 5'd7, 32'h00000004, 1'b0);
    enq(32'h00138433, 5'd7, 5'd1, 5'd8, 32'h00000000, 1'b0);
    @(negedge clk);
    chk("nosb_no_stall", {31'b0, out_valid_o}, 32'd1);
    @(posedge clk); #1;
    wait_drain();
`endif

    // Flush with 3 queued plus the slot, concurrent enqueue dropped.
    out_ready_i = 1'b0;
    enq(32'h00100093, 5'd0, 5'd0, 5'd1, 32'h00000001, 1'b0);
    enq(32'h00200113, 5'd0, 5'd0, 5'd2, 32'h00000002, 1'b0);
    enq(32'h00300193, 5'd0, 5'd0, 5'd3, 32'h00000003, 1'b0);
    enq(32'h00400213, 5'd0, 5'd0, 5'd4, 32'h00000004, 1'b0);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00700393;
    in_pc_i    = pc_next;
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'b0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_drop", {31'b0, out_valid_o}, 32'd0);
    end
    @(posedge clk); #1;

    // Mid-stream reset overrides the handshakes.
    out_ready_i = 1'b0;
    enq(32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1);
    enq(32'h00500293, 5'd0, 5'd0, 5'd5, 32'h00000005, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, out_valid_o}, 32'd1);
    chk("pre_rst_ill",   {31'b0, out_illegal_o}, 32'd1);
    @(posedge clk); #1;
    rst        = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h00600313;
    flush_i    = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("mrst_instr", out_instr_o, 32'd0);
    chk("mrst_pc",    out_pc_o, 32'd0);
    chk("mrst_imm",   out_imm_o, 32'd0);
    chk("mrst_ptrs",  {17'b0, out_rs1_o, out_rs2_o, out_rd_o}, 32'd0);
    chk("mrst_ill",   {31'b0, out_illegal_o}, 32'd0);
    chk("mrst_ready", {31'b0, in_ready_o}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'b0, out_valid_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
